bit_population_generator: RTL and testbench

//  Inverse of the bit population counter: accepts a requested population count and

---
 rtl/bit_population_generator.sv | 163 ++++++++++++++++
 tb/tb_bit_population_generator.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/bit_population_generator.sv
// Generates a WIDTH-bit word with exactly the requested number of bits set, at LFSR-chosen
// positions. Define BIT_POP_GEN_CHECK_EN to add simulation-only population/probe assertions.
module bit_population_generator #(
  parameter int unsigned        WIDTH  = 32,
  parameter int unsigned        LFSR_W = 16,
  parameter logic [LFSR_W-1:0]  SEED   = 16'hACE1
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [$clog2(WIDTH)+1:0] count_i,
  input  logic                     data_val_i,
  output logic                     ready_o,
  output logic [WIDTH-1:0]         data_o,
  output logic                     data_val_o
);

  localparam int unsigned CW = $clog2(WIDTH) + 2;
  localparam int unsigned IW = $clog2(WIDTH);

  // Galois (right-shift) feedback masks of maximal-length polynomials.
  function automatic logic [31:0] lfsr_taps(input int unsigned w);
    case (w)
      2:       return 32'h0000_0003;
      3:       return 32'h0000_0006;
      4:       return 32'h0000_000C;
      5:       return 32'h0000_0014;
      6:       return 32'h0000_0030;
      7:       return 32'h0000_0060;
      8:       return 32'h0000_00B8;
      9:       return 32'h0000_0110;
      10:      return 32'h0000_0240;
      11:      return 32'h0000_0500;
      12:      return 32'h0000_0829;
      13:      return 32'h0000_100D;
      14:      return 32'h0000_2015;
      15:      return 32'h0000_6000;
      16:      return 32'h0000_B400;
      17:      return 32'h0001_2000;
      18:      return 32'h0002_0400;
      19:      return 32'h0004_0023;
      20:      return 32'h0009_0000;
      21:      return 32'h0014_0000;
      22:      return 32'h0030_0000;
      23:      return 32'h0042_0000;
      24:      return 32'h00E1_0000;
      25:      return 32'h0120_0000;
      26:      return 32'h0200_0023;
      27:      return 32'h0400_0013;
      28:      return 32'h0900_0000;
      29:      return 32'h1400_0000;
      30:      return 32'h2000_0029;
      31:      return 32'h4800_0000;
      default: return 32'h8020_0003;
    endcase
  endfunction

  localparam logic [31:0]       TapsAll  = lfsr_taps(LFSR_W);
  localparam logic [LFSR_W-1:0] Taps     = TapsAll[LFSR_W-1:0];
  localparam logic [LFSR_W-1:0] SeedEff  = (SEED == '0) ? LFSR_W'(1) : SEED;

  typedef enum logic [1:0] {StIdle, StFill, StDone} state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  data_q, data_d;
  logic [CW-1:0]     rem_q, rem_d;
  logic [LFSR_W-1:0] lfsr_q, lfsr_d;
  logic [CW-1:0]     count_sat;
  logic [IW-1:0]     idx, pos;
  logic              accept;

  assign accept    = data_val_i && (state_q == StIdle);
  assign count_sat = (count_i > CW'(WIDTH)) ? CW'(WIDTH) : count_i;
  assign idx       = IW'(lfsr_q % LFSR_W'(WIDTH));

  // Probe forward from idx (with wrap) for the first clear bit; a clear bit always exists
  // while remaining is non-zero.
  always_comb begin
    logic [IW:0]   sum;
    logic [IW-1:0] p;
    logic          found;
    pos   = idx;
    found = 1'b0;
    sum   = '0;
    p     = '0;
    for (int unsigned k = 0; k < WIDTH; k++) begin
      sum = {1'b0, idx} + (IW+1)'(k);
      if (sum >= (IW+1)'(WIDTH)) sum = sum - (IW+1)'(WIDTH);
      p = sum[IW-1:0];
      if (!found && !data_q[p]) begin
        pos   = p;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    rem_d   = rem_q;
    lfsr_d  = lfsr_q;
    case (state_q)
      StIdle: begin
        if (accept) begin
          data_d  = '0;
          rem_d   = count_sat;
          state_d = StFill;
        end
      end
      StFill: begin
        if (rem_q == '0) begin
          state_d = StDone;
        end else begin
          data_d[pos] = 1'b1;
          rem_d       = rem_q - CW'(1);
          lfsr_d      = {1'b0, lfsr_q[LFSR_W-1:1]} ^ (lfsr_q[0] ? Taps : '0);
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      data_q  <= '0;
      rem_q   <= '0;
      lfsr_q  <= SeedEff;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      rem_q   <= rem_d;
      lfsr_q  <= lfsr_d;
    end
  end

  assign ready_o    = (state_q == StIdle);
  assign data_val_o = (state_q == StDone);
  assign data_o     = data_q;

`ifdef BIT_POP_GEN_CHECK_EN
  logic [CW-1:0] chk_count_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      chk_count_q <= '0;
    end else if (accept) begin
      chk_count_q <= count_sat;
    end
  end

  always @(posedge clk_i) begin
    if (rst_ni && state_q == StDone) begin
      assert ($countones(data_q) == int'(chk_count_q))
        else $error("population %0d, requested %0d", $countones(data_q), chk_count_q);
    end
    if (rst_ni && state_q == StFill && rem_q != '0) begin
      assert (!data_q[pos]) else $error("fill selected an already-set bit %0d", pos);
    end
  end
`endif

endmodule

// File: tb/tb_bit_population_generator.sv
// Scoreboard bench for bit_population_generator (WIDTH=8): driver queues hand-computed
// expectations, a negedge monitor pops and compares on every data_val_o pulse.
module tb_bit_population_generator;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] count = '0;
  logic       val = 1'b0;
  logic       ready, data_val, ready_b, data_val_b;
  logic [7:0] data, data_b;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    string      name;
    int         n;
    int         acc;
    logic [7:0] da;
    bit         ka;
    logic [7:0] db;
    bit         kb;
  } exp_t;

  exp_t sb[$];
  bit   after_pulse = 1'b0;

  bit_population_generator #(.WIDTH(8), .LFSR_W(16), .SEED(16'hACE1)) dut (
    .clk_i(clk), .rst_ni(rst_n), .count_i(count), .data_val_i(val),
    .ready_o(ready), .data_o(data), .data_val_o(data_val)
  );

  bit_population_generator #(.WIDTH(8), .LFSR_W(16), .SEED(16'h1234)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .count_i(count), .data_val_i(val),
    .ready_o(ready_b), .data_o(data_b), .data_val_o(data_val_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Data pulse at edge T+n+2 means it is visible at the negedge after edge T+n+1.
  always @(negedge clk) begin
    exp_t e;
    if (after_pulse) begin
      check("ready_after_done", int'(ready), 1);
      check("pulse_one_cycle", int'(data_val), 0);
      after_pulse = 1'b0;
    end
    if (data_val) begin
      if (sb.size() == 0) begin
        check("unexpected_pulse", 1, 0);
      end else begin
        e = sb.pop_front();
        check({e.name, "_popcount"}, $countones(data), e.n);
        check({e.name, "_latency"}, cyc - e.acc, e.n + 1);
        if (e.ka) check({e.name, "_data"}, int'(data), int'(e.da));
        check({e.name, "_b_valid"}, int'(data_val_b), 1);
        if (e.kb) check({e.name, "_b_data"}, int'(data_b), int'(e.db));
      end
      after_pulse = 1'b1;
    end
  end

  // Must be entered at a negedge. hold keeps data_val_i high with a junk count while busy.
  task automatic req(input string name, input int c, input bit hold,
                     input logic [7:0] da, input bit ka, input logic [7:0] db, input bit kb);
    int   w;
    exp_t e;
    count = 5'(c);
    val   = 1'b1;
    w = 0;
    while (!ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (!ready) begin
      check({name, "_accept_timeout"}, 0, 1);
      val = 1'b0;
      return;
    end
    e.name = name;
    e.n    = (c > 8) ? 8 : c;
    e.acc  = cyc + 1;
    e.da   = da;
    e.ka   = ka;
    e.db   = db;
    e.kb   = kb;
    sb.push_back(e);
    @(negedge clk);
    if (hold) begin
      count = 5'd7;
      w = 0;
      while (!ready && w < 100) begin
        @(negedge clk);
        w++;
      end
    end
    val = 1'b0;
  endtask

  task automatic drain();
    int w = 0;
    while (sb.size() != 0 && w < 200) begin
      @(negedge clk);
      w++;
    end
    check("drain", sb.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  // Hand-computed with SEED ACE1: index sequence 1,0,0,4,6,7,3,1,4,2,1,0,4,6 from reset.
  task automatic seq_run(input string tag);
    req({tag, "_c0"}, 0, 1'b0, 8'h00, 1'b1, 8'h00, 1'b1);
    req({tag, "_c3"}, 3, 1'b0, 8'h07, 1'b1, 8'h34, 1'b1);
    req({tag, "_c2"}, 2, 1'b0, 8'h50, 1'b1, 8'h00, 1'b0);
    req({tag, "_c4"}, 4, 1'b1, 8'h9A, 1'b1, 8'h00, 1'b0);
    req({tag, "_c5"}, 5, 1'b0, 8'h57, 1'b1, 8'h00, 1'b0);
    drain();
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("idle_ready", int'(ready), 1);
      check("idle_valid", int'(data_val), 0);
      check("idle_data", int'(data), 0);
    end

    seq_run("run1");

    req("full8", 8, 1'b0, 8'hFF, 1'b1, 8'hFF, 1'b1);
    req("sat20", 20, 1'b0, 8'hFF, 1'b1, 8'hFF, 1'b1);
    drain();

    for (int c = 0; c <= 8; c++) begin
      req($sformatf("sweep%0d", c), c, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    drain();

    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    seq_run("run2");

    // Abort a count-6 fill with an asynchronous reset three edges after acceptance.
    count = 5'd6;
    val   = 1'b1;
    @(posedge clk);
    #1 val = 1'b0;
    repeat (3) @(posedge clk);
    #1 check("midfill_popcount", $countones(data), 3);
    #1 rst_n = 1'b0;
    #1;
    check("rst_ready", int'(ready), 1);
    check("rst_valid", int'(data_val), 0);
    check("rst_data", int'(data), 0);
    check("rst_b_data", int'(data_b), 0);
    @(negedge clk);
    rst_n = 1'b1;
    req("post_rst_c3", 3, 1'b0, 8'h07, 1'b1, 8'h34, 1'b1);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
